// File: rtl/tt10_xor_shift.sv
// rtl/tt10_xor_shift.sv - registered 8-bit xor with conditional left shift
module tt10_xor_shift (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out
);

  logic [7:0] xor_val;
  logic [7:0] uo_out_d;
  logic [7:0] uo_out_q;

  // Next result: xor of the operands, shifted left by one when A[7] selects it
  always_comb begin
    xor_val  = ui_in ^ uio_in;
    uo_out_d = xor_val;
    if (ui_in[7]) begin
      uo_out_d = {xor_val[6:0], 1'b0};
    end
  end

  // Single output register; reset clears it at the edge, never between edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uo_out_q <= 8'h00;
    end else begin
      uo_out_q <= uo_out_d;
    end
  end

  assign uo_out = uo_out_q;

endmodule

// File: tb/tb_tt10_xor_shift.sv
// tb/tb_tt10_xor_shift.sv - self-checking bench for tt10_xor_shift
module tb_tt10_xor_shift;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[12];

  tt10_xor_shift dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic, shift expressed as multiply-by-two modulo 256
  function automatic logic [7:0] model(input logic r, input int a, input int b);
    int x;
    if (!r) return 8'h00;
    x = a ^ b;
    if (a >= 128) x = (x * 2) % 256;
    return x[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] a, input logic [7:0] b);
    rst_n  = r;
    ui_in  = a;
    uio_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    ui_in  = 8'h55;
    uio_in = 8'h33;

    tbl[0]  = '{1'b0, 8'h55, 8'h33, 8'h00, "reset_edge1"};
    tbl[1]  = '{1'b0, 8'h55, 8'h33, 8'h00, "reset_edge2"};
    tbl[2]  = '{1'b1, 8'h55, 8'h33, 8'h66, "noshift_1"};
    tbl[3]  = '{1'b1, 8'h55, 8'h33, 8'h66, "noshift_2"};
    tbl[4]  = '{1'b1, 8'hD5, 8'h33, 8'hCC, "shift_msb_drop"};
    tbl[5]  = '{1'b1, 8'hFF, 8'hFF, 8'h00, "equal_ops_shift"};
    tbl[6]  = '{1'b1, 8'h80, 8'h00, 8'h00, "pipe_80_00"};
    tbl[7]  = '{1'b1, 8'h01, 8'h02, 8'h03, "pipe_01_02"};
    tbl[8]  = '{1'b1, 8'hC0, 8'h40, 8'h00, "pipe_c0_40"};
    tbl[9]  = '{1'b1, 8'h81, 8'h00, 8'h02, "pipe_81_00"};
    tbl[10] = '{1'b1, 8'h7F, 8'h80, 8'hFF, "b7_not_select"};
    tbl[11] = '{1'b1, 8'h80, 8'h7F, 8'hFE, "a7_x7_lost"};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst_n, tbl[i].a, tbl[i].b);
      check(tbl[i].name, uo_out, tbl[i].exp);
    end

    // Mid-operation reset pulse across one edge with inputs held
    step(1'b1, 8'h55, 8'h33);
    check("mid_pre", uo_out, 8'h66);
    rst_n = 1'b0;
    #2;
    check("mid_no_async_assert", uo_out, 8'h66);
    @(posedge clk);
    #1;
    check("mid_reset_edge", uo_out, 8'h00);
    rst_n = 1'b1;
    #2;
    check("mid_no_async_release", uo_out, 8'h00);
    @(posedge clk);
    #1;
    check("mid_resume", uo_out, 8'h66);

    // Input change between edges must not reach the output early
    ui_in  = 8'h01;
    uio_in = 8'h10;
    #2;
    check("no_comb_path", uo_out, 8'h66);
    @(posedge clk);
    #1;
    check("late_change_taken", uo_out, 8'h11);

    // Randomized stimulus against the reference model, occasional reset
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [7:0] a;
      logic [7:0] b;
      r = ($urandom_range(0, 15) != 0);
      a = 8'($urandom_range(0, 255));
      b = (i % 17 == 0) ? a : 8'($urandom_range(0, 255));
      step(r, a, b);
      check("random", uo_out, model(r, int'(a), int'(b)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
